vga_timing: RTL and testbench
=============================

# vga_timing

Free-running 640x480@60 raster timing generator on the 25 MHz pixel clock. Produces the pixel coordinates, sync pulses and blanking flags consumed by the downstream pixel logic and the VGA pins. Also provides single-cycle line/frame start strobes, so downstream logic can update per-frame state synchronously instead of clocking on `vsync`.

## Interface
Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, active lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `SYNC_ACTIVE`, 0, asserted level of `hsync`/`vsync` (0 = negative polarity)

Ports:
- `clk` in 1 — 25 MHz pixel clock; the only clock
- `rst` in 1 — synchronous, active-high reset
- `pixelx` out 11 — horizontal counter, 0..H_TOTAL-1
- `pixely` out 11 — vertical counter, 0..V_TOTAL-1
- `hsync` out 1 — horizontal sync
- `vsync` out 1 — vertical sync
- `active` out 1 — 1 when pixelx<H_VISIBLE and pixely<V_VISIBLE
- `line_start` out 1 — 1-cycle strobe, pixelx==0
- `frame_start` out 1 — 1-cycle strobe, pixelx==0 and pixely==0
- `frame_count` out 16 — present only with `VGA_TIMING_FRAME_COUNT_EN`

## Operation
- Derived totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Width check: each total must be ≤2048, because coordinates are 11 bits.
- Horizontal counter behaviour:
  - `pixelx` increments every cycle.
  - At H_TOTAL-1 it wraps to 0.
- Vertical counter behaviour:
  - `pixely` increments only on the cycle `pixelx` wraps.
  - At V_TOTAL-1, on a line wrap, it wraps to 0.
- All outputs are registers decoded from the next counter values, so every flag is aligned with the `pixelx`/`pixely` it describes in the same cycle.
- `hsync` equals SYNC_ACTIVE iff pixelx ∈ [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], i.e. 656..751 at defaults.
- `vsync` equals SYNC_ACTIVE iff pixely ∈ [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1], i.e. 490..491 at defaults.
  - `vsync` changes only in cycles where pixelx==0.
- Horizontal phases ACTIVE→FRONT→SYNC→BACK→ACTIVE are implied by pixelx ranges; no separate FSM state is exposed.
- Reset state: counters load pixelx=H_TOTAL-1 (799) and pixely=V_TOTAL-1 (524). All outputs hold the decode of that point:
  - `hsync` = `vsync` = !SYNC_ACTIVE (1)
  - `active` = 0
  - `line_start` = `frame_start` = 0
- `rst` asserted mid-frame: the next edge forces the reset state, with no partial pulse stretch. `rst` dominates every other update.

## Timing
- First edge with `rst`=0 gives pixelx=0, pixely=0, active=1, line_start=1, frame_start=1.
- Line period: 800 cycles. Frame period: 420000 cycles.
- `hsync` is asserted for exactly 96 consecutive cycles per line, on every line including vertical blanking.
- `vsync` is asserted for exactly 1600 consecutive cycles (2 lines), starting at (0,490).
- Deassert edge (0→1 at defaults) occurs at (0,492).
- `active` is high for 640 cycles per line on lines 0..479, and 307200 cycles per frame.
- Zero latency between counter value and flags; one-cycle register latency from `rst` release.

## Configuration
- `VGA_TIMING_FRAME_COUNT_EN` defined:
  - `frame_count` port exists, resets to 0.
  - Increments by 1 in the same cycle `frame_start` asserts, except the first post-reset frame_start, which leaves it 0.
  - Wraps 65535→0.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release → first cycle (0,0), active=1, frame_start=1, hsync=vsync=1; during rst, (799,524), active=0.
- Run one line → pixelx 0..799 then 0, pixely 0→1 at cycle 800, hsync=0 exactly at pixelx 656..751, line_start only at pixelx=0.
- Run full frame → frame_start period 420000 cycles, vsync=0 for cycles with pixely 490..491 only, pixely wraps 524→0, active count 307200.
- Assert rst at (300,200) for 3 cycles → outputs at reset state each cycle; after release, (0,0) with frame_start=1.
- SYNC_ACTIVE=1 build → hsync/vsync polarities inverted, reset value 0, all positions unchanged.
- With VGA_TIMING_FRAME_COUNT_EN → frame_count 0,1,2 at successive frame_starts; forced to 65535, next frame_start → 0.

Source files
------------

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator (640x480@60 by default).
// Produces pixel coordinates, sync pulses, the active-video flag, and
// line/frame start strobes. Every output is a register decoded from the
// next counter values, so each flag lines up with the coordinates it describes.
// Optional feature: define VGA_TIMING_FRAME_COUNT_EN to add a 16-bit frame counter.
module vga_timing #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned H_FRONT     = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter bit          SYNC_ACTIVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] pixelx,
    output logic [10:0] pixely,
    output logic        hsync,
    output logic        vsync,
    output logic        active,
    output logic        line_start,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int unsigned CW       = 11;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    // Coordinates are 11 bits wide; refuse configurations that cannot fit.
    if (H_TOTAL > 2048) begin : g_h_total_too_big
        $error("vga_timing: H_TOTAL exceeds the 11-bit coordinate range");
    end
    if (V_TOTAL > 2048) begin : g_v_total_too_big
        $error("vga_timing: V_TOTAL exceeds the 11-bit coordinate range");
    end

    logic [CW-1:0] next_x;
    logic [CW-1:0] next_y;
    logic          next_hsync;
    logic          next_vsync;
    logic          next_active;
    logic          next_line_start;
    logic          next_frame_start;

    // Next raster position plus the decode of that position.
    always_comb begin
        next_x = pixelx + CW'(1);
        next_y = pixely;
        if (pixelx == CW'(H_TOTAL - 1)) begin
            next_x = '0;
            if (pixely == CW'(V_TOTAL - 1)) begin
                next_y = '0;
            end else begin
                next_y = pixely + CW'(1);
            end
        end

        next_hsync = ~SYNC_ACTIVE;
        if ((32'(next_x) >= HS_START) && (32'(next_x) < HS_END)) begin
            next_hsync = SYNC_ACTIVE;
        end

        next_vsync = ~SYNC_ACTIVE;
        if ((32'(next_y) >= VS_START) && (32'(next_y) < VS_END)) begin
            next_vsync = SYNC_ACTIVE;
        end

        next_active      = (32'(next_x) < H_VISIBLE) && (32'(next_y) < V_VISIBLE);
        next_line_start  = (next_x == '0);
        next_frame_start = (next_x == '0) && (next_y == '0);
    end

    // Counters and decoded flags; reset parks the raster on the last pixel of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixelx      <= CW'(H_TOTAL - 1);
            pixely      <= CW'(V_TOTAL - 1);
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixelx      <= next_x;
            pixely      <= next_y;
            hsync       <= next_hsync;
            vsync       <= next_vsync;
            active      <= next_active;
            line_start  <= next_line_start;
            frame_start <= next_frame_start;
        end
    end

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic frame_seen;

    // Frame counter; the first frame after reset is frame 0, so its start does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= '0;
            frame_seen  <= 1'b0;
        end else if (next_frame_start) begin
            frame_seen <= 1'b1;
            if (frame_seen) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: a default-size instance for reset and one
// full line, plus two shrunken-raster instances (16x11 total, both sync
// polarities) so full frames, wrap and mid-frame reset fit in a short run.
module tb_vga_timing;

    logic clk;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    // Default 640x480 instance
    logic [10:0] d_x, d_y;
    logic        d_hs, d_vs, d_act, d_ls, d_fs;
    // Small instance, negative sync: H 8/2/3/3 (hsync x=10..12), V 6/1/2/2 (vsync y=7..8)
    logic [10:0] s_x, s_y;
    logic        s_hs, s_vs, s_act, s_ls, s_fs;
    // Same small raster, positive sync
    logic [10:0] p_x, p_y;
    logic        p_hs, p_vs, p_act, p_ls, p_fs;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc, p_fc;
`endif

    vga_timing dut (
        .clk(clk), .rst(rst), .pixelx(d_x), .pixely(d_y), .hsync(d_hs), .vsync(d_vs),
        .active(d_act), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(d_fc)
`endif
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b0)
    ) dut_s (
        .clk(clk), .rst(rst), .pixelx(s_x), .pixely(s_y), .hsync(s_hs), .vsync(s_vs),
        .active(s_act), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    vga_timing #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_ACTIVE(1'b1)
    ) dut_p (
        .clk(clk), .rst(rst), .pixelx(p_x), .pixely(p_y), .hsync(p_hs), .vsync(p_vs),
        .active(p_act), .line_start(p_ls), .frame_start(p_fs)
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .frame_count(p_fc)
`endif
    );

    // 25 MHz pixel clock
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int x_bad, y_bad, hs_cnt, hs_first, hs_last, ls_cnt, act_cnt;
        int s_hs_cnt, s_vs_cnt, s_vs_first, s_vs_last, s_act_cnt, vs_bad, fs_cnt, fs_last;
        int p_hs_cnt, p_vs_cnt, p_vs_first, y175, x176, y176;
        logic prev_vs;

        // ---- reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pixelx", 32'(d_x), 799);
        check("rst_pixely", 32'(d_y), 524);
        check("rst_hsync", 32'(d_hs), 1);
        check("rst_vsync", 32'(d_vs), 1);
        check("rst_active", 32'(d_act), 0);
        check("rst_line_start", 32'(d_ls), 0);
        check("rst_frame_start", 32'(d_fs), 0);
        check("rst_small_x", 32'(s_x), 15);
        check("rst_small_y", 32'(s_y), 10);
        check("rst_pos_hsync", 32'(p_hs), 0);
        check("rst_pos_vsync", 32'(p_vs), 0);

        // ---- first cycle after release ----
        rst = 1'b0;
        @(negedge clk);
        check("rel_pixelx", 32'(d_x), 0);
        check("rel_pixely", 32'(d_y), 0);
        check("rel_active", 32'(d_act), 1);
        check("rel_line_start", 32'(d_ls), 1);
        check("rel_frame_start", 32'(d_fs), 1);
        check("rel_hsync", 32'(d_hs), 1);
        check("rel_vsync", 32'(d_vs), 1);

        // ---- one full default line ----
        x_bad = 0; y_bad = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; act_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            if (c > 0) @(negedge clk);
            if (32'(d_x) != c) x_bad++;
            if (d_y != 11'd0) y_bad++;
            if (d_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = c;
                hs_last = c;
            end
            if (d_ls === 1'b1) ls_cnt++;
            if (d_act === 1'b1) act_cnt++;
        end
        check("line_x_sequence_errs", 32'(x_bad), 0);
        check("line_y_stays_0_errs", 32'(y_bad), 0);
        check("line_hsync_count", 32'(hs_cnt), 96);
        check("line_hsync_first", 32'(hs_first), 656);
        check("line_hsync_last", 32'(hs_last), 751);
        check("line_line_start_count", 32'(ls_cnt), 1);
        check("line_active_count", 32'(act_cnt), 640);
        @(negedge clk);
        check("line2_pixelx", 32'(d_x), 0);
        check("line2_pixely", 32'(d_y), 1);
        check("line2_line_start", 32'(d_ls), 1);
        check("line2_frame_start", 32'(d_fs), 0);
        check("line2_vsync", 32'(d_vs), 1);

        // ---- small raster: two full frames plus the third frame start ----
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        s_hs_cnt = 0; s_vs_cnt = 0; s_vs_first = -1; s_vs_last = -1; s_act_cnt = 0;
        vs_bad = 0; fs_cnt = 0; fs_last = -1;
        p_hs_cnt = 0; p_vs_cnt = 0; p_vs_first = -1; y175 = -1; x176 = -1; y176 = -1;
        prev_vs = s_vs;
        for (int c = 0; c <= 352; c++) begin
            if (c > 0) @(negedge clk);
            if (c > 0 && s_vs !== prev_vs && s_x != 11'd0) vs_bad++;
            prev_vs = s_vs;
            if (s_fs === 1'b1) begin
                fs_cnt++;
                fs_last = c;
            end
            if (c < 176) begin
                if (s_hs === 1'b0) s_hs_cnt++;
                if (s_vs === 1'b0) begin
                    s_vs_cnt++;
                    if (s_vs_first < 0) s_vs_first = c;
                    s_vs_last = c;
                end
                if (s_act === 1'b1) s_act_cnt++;
                if (p_hs === 1'b1) p_hs_cnt++;
                if (p_vs === 1'b1) begin
                    p_vs_cnt++;
                    if (p_vs_first < 0) p_vs_first = c;
                end
            end
            if (c == 175) y175 = 32'(s_y);
            if (c == 176) begin
                x176 = 32'(s_x);
                y176 = 32'(s_y);
            end
`ifdef VGA_TIMING_FRAME_COUNT_EN
            if (c == 0)   check("fc_frame0", 32'(s_fc), 0);
            if (c == 176) check("fc_frame1", 32'(s_fc), 1);
            if (c == 352) check("fc_frame2", 32'(s_fc), 2);
`endif
        end
        check("frm_frame_start_count", 32'(fs_cnt), 3);
        check("frm_frame_start_last", 32'(fs_last), 352);
        check("frm_hsync_count", 32'(s_hs_cnt), 33);
        check("frm_vsync_count", 32'(s_vs_cnt), 32);
        check("frm_vsync_first", 32'(s_vs_first), 112);
        check("frm_vsync_last", 32'(s_vs_last), 143);
        check("frm_vsync_off_x0_changes", 32'(vs_bad), 0);
        check("frm_active_count", 32'(s_act_cnt), 48);
        check("frm_y_before_wrap", 32'(y175), 10);
        check("frm_x_after_wrap", 32'(x176), 0);
        check("frm_y_after_wrap", 32'(y176), 0);
        check("pos_hsync_count", 32'(p_hs_cnt), 33);
        check("pos_vsync_count", 32'(p_vs_cnt), 32);
        check("pos_vsync_first", 32'(p_vs_first), 112);

        // ---- reset in the middle of an hsync pulse at (11,4) ----
        repeat (75) @(negedge clk);
        check("mid_pre_x", 32'(s_x), 11);
        check("mid_pre_y", 32'(s_y), 4);
        check("mid_pre_hsync", 32'(s_hs), 0);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_rst_x", 32'(s_x), 15);
            check("mid_rst_y", 32'(s_y), 10);
            check("mid_rst_hsync", 32'(s_hs), 1);
            check("mid_rst_active", 32'(s_act), 0);
            check("mid_rst_frame_start", 32'(s_fs), 0);
            check("mid_rst_pos_hsync", 32'(p_hs), 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("mid_rel_x", 32'(s_x), 0);
        check("mid_rel_y", 32'(s_y), 0);
        check("mid_rel_frame_start", 32'(s_fs), 1);
        check("mid_rel_line_start", 32'(s_ls), 1);
        check("mid_rel_active", 32'(s_act), 1);
        check("mid_rel_hsync", 32'(s_hs), 1);

`ifdef VGA_TIMING_FRAME_COUNT_EN
        // ---- frame counter wrap ----
        check("fc_after_reset", 32'(s_fc), 0);
        force dut_s.frame_count = 16'hFFFF;
        #1;
        release dut_s.frame_count;
        repeat (176) @(negedge clk);
        check("fc_wrap_frame_start", 32'(s_fs), 1);
        check("fc_wrap_value", 32'(s_fc), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
